axi_fill_check: RTL
===================

AXI_FILL_CHECK -- requirements
Module: axi_fill_check

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 32, AXI data width in bits.
- ADDR_WIDTH, 16, AXI byte address width.
- STRB_WIDTH, DATA_WIDTH/8, bytes per beat; power of two.
- ID_WIDTH, 8, AXI ID width.
- MAX_BURST_LEN, 16, beats per burst; power of two, 1..256; MAX_BURST_LEN*STRB_WIDTH divides 4096.
- TXN_ID, 0, constant value driven on awid and arid.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, reset; synchronous, active-high.
- cmd_valid / cmd_ready, in / out, 1 / 1, command handshake.
- cmd_addr, in, ADDR_WIDTH, base byte address; low log2(MAX_BURST_LEN*STRB_WIDTH) bits treated as zero.
- cmd_words, in, 16, number of beats to fill, then check.
- cmd_seed, in, DATA_WIDTH, pattern seed.
- busy, out, 1, high from command acceptance until done.
- done, out, 1, single-cycle completion pulse.
- err_count, out, 16, mismatches in the last command; valid while done is high; held until the next command is accepted.
- m_axi_aw*/w*/b*/ar*/r*, AXI4 master: id, addr, len, size, burst, lock, cache, prot, valid, ready, data, strb, last, resp, at standard widths.

Function
REQ-003 cmd_ready SHALL equal (state==IDLE); a command SHALL be accepted on the cycle where cmd_valid and cmd_ready are both high.
REQ-004 The state machine SHALL have states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-005 Acceptance with cmd_words>0 SHALL go to WR_ADDR next cycle. cmd_words==0 SHALL go to DONE; no AXI traffic, err_count=0.
REQ-006 Each burst SHALL use length min(remaining, MAX_BURST_LEN). Fixed fields: axlen=beats-1, axsize=log2(STRB_WIDTH), axburst=INCR(01), lock=0, cache=0011, prot=000, wstrb all ones. Exactly one burst outstanding at a time.
REQ-007 WR_ADDR: awvalid high until awready; then WR_DATA.
REQ-008 WR_DATA: wvalid high. Beat k of the command (k=0..cmd_words-1, global index) SHALL carry wdata=cmd_seed+k, modulo 2^DATA_WIDTH. wlast high on the final beat of the burst. W SHALL NOT be driven before AW is accepted.
REQ-009 WR_DATA ends with bready high in WR_RESP. On bvalid: bresp!=00 SHALL add 1 to the error count. Then go to WR_ADDR if write beats remain, else RD_ADDR with the address reset to base.
REQ-010 RD_ADDR/RD_DATA SHALL mirror the write bursts: identical addresses and lengths, rready high throughout RD_DATA.
REQ-011 Per R beat, at most 1 SHALL be added to the error count if any of the following holds: rdata != cmd_seed+k; rresp != 00; rlast differs from (beat is last of burst). RD_DATA SHALL leave on the expected last beat regardless of rlast.
REQ-012 After the final read burst, the block SHALL enter DONE for one cycle (done=1), then IDLE.
REQ-013 The error counter SHALL saturate at 16'hFFFF. It SHALL clear on command acceptance.
REQ-014 The burst address SHALL advance by beats*STRB_WIDTH per burst and wrap modulo 2^ADDR_WIDTH.
REQ-015 All AXI outputs, cmd_ready, busy and done SHALL be registered, with no combinational input-to-output paths.

Reset
REQ-016 When rst is high, the block SHALL go to IDLE. Reset values: cmd_ready=0 for the reset cycle, then 1; busy=0, done=0, err_count=0; awvalid=0, wvalid=0, bready=0, arvalid=0, rready=0.
REQ-017 Reset mid-operation SHALL abandon the transaction immediately. The attached slave SHALL be reset concurrently.

Structure
REQ-018 State encodings and AXI fixed-field constants SHALL be module-local localparams. No shared package is needed; no sub-module is needed. Counters SHALL be 16-bit (total beats) and 9-bit (burst beats).

Verification
REQ-019 The bench SHALL pair the DUT with the team's AXI RAM model (DATA_WIDTH 32) and cover:
- addr=0x0000, words=40, seed=0x100 -> bursts of 16, 16, 8 for both write and read; RAM word 39 = 0x127; done with err_count=0.
- words=0 -> done 1 cycle after accept, no awvalid, err_count=0.
- words=16, seed=0; bench corrupts RAM word 5 between the write and read phases -> err_count=1.
- Random backpressure on awready/wready/bvalid/arready/rvalid, words=33 -> data intact, err_count=0.
- Slave forced bresp=10 on all bursts, words=32 -> err_count=2.
- rst asserted mid WR_DATA -> next cycle all valids 0, busy 0; a new command then completes with err_count=0.

Source files
------------

// File: rtl/axi_fill_check.sv
// AXI4 memory fill-and-verify master: writes cmd_seed+k to cmd_words beats,
// then reads the same region back and counts beats that do not match.
module axi_fill_check #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH/8,
  parameter int ID_WIDTH      = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int TXN_ID        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_words,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [ID_WIDTH-1:0]   AXI_ID         = ID_WIDTH'(TXN_ID);
  localparam logic [2:0]            AXI_SIZE       = 3'($clog2(STRB_WIDTH));
  localparam logic [1:0]            AXI_BURST_INCR = 2'b01;
  localparam logic [3:0]            AXI_CACHE      = 4'b0011;
  localparam logic [2:0]            AXI_PROT       = 3'b000;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK     = ~ADDR_WIDTH'(MAX_BURST_LEN*STRB_WIDTH-1);
  localparam logic [8:0]            MAX_BEATS      = 9'(MAX_BURST_LEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0, WR_ADDR = 3'd1, WR_DATA = 3'd2, WR_RESP = 3'd3,
    RD_ADDR = 3'd4, RD_DATA = 3'd5, DONE = 3'd6
  } state_e;

  function automatic logic [8:0] burst_beats(input logic [15:0] remaining);
    return (remaining >= 16'(MAX_BURST_LEN)) ? MAX_BEATS : remaining[8:0];
  endfunction

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic [DATA_WIDTH-1:0] seed_q, wdata_q;
  logic [15:0]           words_total_q, words_left_q, beat_q, err_q;
  logic [8:0]            burst_left_q;
  logic [7:0]            len_q;
  logic                  cmd_ready_q, busy_q, done_q;
  logic                  awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;

  logic [ADDR_WIDTH-1:0] next_addr_d;
  logic [DATA_WIDTH-1:0] expect_d;
  logic [15:0]           err_inc_d;
  logic [8:0]            cmd_beats_d, left_beats_d, left_m1_beats_d, total_beats_d;
  logic                  rd_bad_d;

  assign next_addr_d     = addr_q + ADDR_WIDTH'((32'(len_q) + 32'd1) * 32'(STRB_WIDTH));
  assign expect_d        = seed_q + DATA_WIDTH'(beat_q);
  assign err_inc_d       = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
  assign cmd_beats_d     = burst_beats(cmd_words);
  assign left_beats_d    = burst_beats(words_left_q);
  assign left_m1_beats_d = burst_beats(words_left_q - 16'd1);
  assign total_beats_d   = burst_beats(words_total_q);
  // A read beat counts at most once, however many of its fields are wrong.
  assign rd_bad_d = (m_axi_rdata != expect_d) || (m_axi_rresp != 2'b00) ||
                    (m_axi_rlast != (burst_left_q == 9'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0; addr_q <= '0; seed_q <= '0; wdata_q <= '0;
      words_total_q <= '0; words_left_q <= '0; beat_q <= '0; err_q <= '0;
      burst_left_q <= '0; len_q <= '0;
      cmd_ready_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
      awvalid_q <= 1'b0; wvalid_q <= 1'b0; wlast_q <= 1'b0;
      bready_q <= 1'b0; arvalid_q <= 1'b0; rready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q   <= 1'b0;
            seed_q        <= cmd_seed;
            base_q        <= cmd_addr & ALIGN_MASK;
            addr_q        <= cmd_addr & ALIGN_MASK;
            words_total_q <= cmd_words;
            words_left_q  <= cmd_words;
            beat_q        <= '0;
            err_q         <= '0;
            burst_left_q  <= cmd_beats_d;
            len_q         <= 8'(cmd_beats_d - 9'd1);
            if (cmd_words == 16'd0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              busy_q    <= 1'b1;
              awvalid_q <= 1'b1;
              state_q   <= WR_ADDR;
            end
          end
        end
        WR_ADDR: if (m_axi_awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          wdata_q   <= expect_d;
          wlast_q   <= (burst_left_q == 9'd1);
          state_q   <= WR_DATA;
        end
        WR_DATA: if (m_axi_wready) begin
          beat_q       <= beat_q + 16'd1;
          words_left_q <= words_left_q - 16'd1;
          burst_left_q <= burst_left_q - 9'd1;
          wdata_q      <= expect_d + DATA_WIDTH'(1);
          wlast_q      <= (burst_left_q == 9'd2);
          if (wlast_q) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (m_axi_bvalid) begin
          bready_q <= 1'b0;
          if (m_axi_bresp != 2'b00) err_q <= err_inc_d;
          if (words_left_q != 16'd0) begin
            addr_q       <= next_addr_d;
            burst_left_q <= left_beats_d;
            len_q        <= 8'(left_beats_d - 9'd1);
            awvalid_q    <= 1'b1;
            state_q      <= WR_ADDR;
          end else begin
            // Read phase replays the same burst sequence from the base address.
            addr_q       <= base_q;
            words_left_q <= words_total_q;
            beat_q       <= '0;
            burst_left_q <= total_beats_d;
            len_q        <= 8'(total_beats_d - 9'd1);
            arvalid_q    <= 1'b1;
            state_q      <= RD_ADDR;
          end
        end
        RD_ADDR: if (m_axi_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (m_axi_rvalid) begin
          if (rd_bad_d) err_q <= err_inc_d;
          beat_q       <= beat_q + 16'd1;
          words_left_q <= words_left_q - 16'd1;
          burst_left_q <= burst_left_q - 9'd1;
          // Burst end is decided by our own beat count, never by rlast.
          if (burst_left_q == 9'd1) begin
            rready_q <= 1'b0;
            if (words_left_q != 16'd1) begin
              addr_q       <= next_addr_d;
              burst_left_q <= left_m1_beats_d;
              len_q        <= 8'(left_m1_beats_d - 9'd1);
              arvalid_q    <= 1'b1;
              state_q      <= RD_ADDR;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, m_axi_rid};

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_q;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
